// File: rtl/scan_pkg.sv
// Shared definitions for the truth-table scanner.
//   scan_state_e  : scanner FSM state encoding
//   ExpectDefault : reference capture table for the 3-input/2-output cell
//   CntWidth      : settle counter width (covers SETTLE up to 15)
package scan_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } scan_state_e;

  localparam logic [15:0] ExpectDefault = 16'h85D8;
  localparam int unsigned CntWidth      = 4;

endpackage

// File: rtl/settle_counter.sv
// Settle counter for the truth-table scanner.
//   clk, rst : clock and asynchronous active-high reset
//   load     : clear the count to zero (has priority over enable)
//   enable   : increment the count
//   tc       : terminal count, high while the count equals SETTLE-1
module settle_counter
  import scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic tc
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CntWidth'(SETTLE - 1));

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: steps a 3-input cell through all eight input vectors,
// holds each for SETTLE cycles, samples the two responses and compares the
// assembled 16-bit table against EXPECT.
//   clk, rst     : clock and asynchronous active-high reset
//   start        : launch a scan (only honoured in idle)
//   A, B, C      : registered stimulus, {A,B,C} = current vector index
//   X, Y         : cell responses, captured once per vector
//   busy         : scan in progress (drive or sample)
//   done         : one-cycle pulse when the scan completes
//   result_table : captured responses, bits [2i+1:2i] = {Y,X} for vector i
//   mismatch     : completed table differs from EXPECT
module truth_table_scanner
  import scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] EXPECT = ExpectDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        A,
  output logic        B,
  output logic        C,
  input  logic        X,
  input  logic        Y,
  output logic        busy,
  output logic        done,
  output logic [15:0] result_table,
  output logic        mismatch
);

  scan_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] table_q, table_d;
  logic        mismatch_q, mismatch_d;
  logic        cnt_load, cnt_en, cnt_tc;

  settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    table_d    = table_q;
    mismatch_d = mismatch_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StDrive;
          idx_d      = 3'd0;
          cnt_load   = 1'b1;
          table_d    = '0;
          mismatch_d = 1'b0;
        end
      end
      StDrive: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = StSample;
        end
      end
      StSample: begin
        table_d[{idx_q, 1'b0} +: 2] = {Y, X};
        if (idx_q == 3'd7) begin
          idx_d      = 3'd0;
          state_d    = StDone;
          // Compare the table including the capture made on this same edge.
          mismatch_d = (table_d != EXPECT);
        end else begin
          idx_d    = idx_q + 3'd1;
          cnt_load = 1'b1;
          state_d  = StDrive;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      table_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      table_q    <= table_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Stimulus is the index register itself, so it only moves on drive entry
  // (and back to zero when the scan wraps into done).
  assign {A, B, C}    = idx_q;
  assign busy         = (state_q == StDrive) || (state_q == StSample);
  assign done         = (state_q == StDone);
  assign result_table = table_q;
  assign mismatch     = mismatch_q;

endmodule
